mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port program/data RAM between NREQ requesters: CPU memory port (MAR/MBR side, idx 0),
//  program loader (idx 1), debug/DMA (further idx). Round-robin, at most one RAM access per cycle.
//  Per-requester handshake plus returned-read tagging; `busy` feeds the CPU stall/hold logic.
// PARAMETERS
//  NREQ      2   number of requesters (2..4)
//  AW        8   RAM address width
//  DW        16  RAM data width
//  RD_LAT    1   RAM read latency in cycles (1..3)
//  MAX_HOLD  16  max consecutive locked grants before forced release (ARB_LOCK_EN only)
// PORTS
//  clk        in   1        system clock
//  rst        in   1        reset: synchronous, active-high
//  req        in   NREQ     access request per requester; held until granted
//  lock       in   NREQ     keep ownership after this grant (ignored without ARB_LOCK_EN)
//  req_we     in   NREQ     1=write, 0=read
//  req_addr   in   NREQ*AW  flattened addresses; requester i at [i*AW +: AW]
//  req_wdata  in   NREQ*DW  flattened write data
//  gnt        out  NREQ     one-hot; access issued this cycle
//  rvalid     out  NREQ     one-hot; rdata valid for that requester
//  rdata      out  DW       read data, broadcast (= mem_rdata)
//  busy       out  1        any read in flight or LOCKED state
//  mem_addr   out  AW       RAM address
//  mem_we     out  1        RAM write enable
//  mem_wdata  out  DW       RAM write data
//  mem_rdata  in   DW       RAM read data, RD_LAT cycles after address
// BEHAVIOUR
//  - Grant is combinational in the request cycle: gnt[i]=1 => mem_addr/mem_we/mem_wdata = requester i fields
//    in the same cycle. No grant => mem_we=0, mem_addr=0, mem_wdata=0.
//  - Round-robin: search starts at (last_gnt+1) mod NREQ; last_gnt updates only on grant.
//    After reset last_gnt=NREQ-1, so idx 0 has top priority.
//  - Reads: granted read pushes (valid,id) into a RD_LAT-deep shift pipe; rvalid[id]=1 exactly RD_LAT
//    cycles after gnt. Writes never produce rvalid. Back-to-back reads from any mix of requesters:
//    one rvalid per cycle, in issue order.
//  - FSM (state in pkg): IDLE (no grant last cycle), ARB (granted last cycle, unlocked), LOCKED (owner fixed).
//    IDLE/ARB -> ARB on grant, -> IDLE on no grant, -> LOCKED on grant with lock[i]=1 (ARB_LOCK_EN).
//  - Reset: gnt=0, rvalid=0, busy=0, mem_we=0, mem_addr=0, pipe cleared, state IDLE, hold_cnt=0.
//    Reads in flight at reset are dropped: no rvalid after rst.
//  - req deasserted before grant: allowed, no access. req_* fields must stay stable while req=1 and gnt=0.
// CONFIGURATION
//  `ARB_LOCK_EN` defined:
//   - LOCKED: only owner may be granted; others see gnt=0.
//   - hold_cnt increments per owner grant.
//   - Leave LOCKED (to ARB) when owner lock=0 (that cycle's request is still granted to owner)
//     or hold_cnt reaches MAX_HOLD (forced release; last_gnt=owner so owner gets lowest priority next).
//   - Owner req=0 with lock=1: no grant, stay LOCKED, hold_cnt keeps counting idle cycles.
//  `ARB_LOCK_EN` undefined: lock ignored, LOCKED unreachable, pure round-robin; port list unchanged.
// STRUCTURE
//  - mem_arb_pkg: arb_state_t {IDLE,ARB,LOCKED}, default NREQ/AW/DW, clog2 helper for id width.
//  - Sub-module mem_arb_rr_pick: combinational round-robin picker (req, last_gnt -> one-hot gnt),
//    reused by the lock path with a masked req.
// TESTING
//  1 rst=1 two cycles with req=2'b11 -> gnt=0, mem_we=0, rvalid=0; first cycle after rst: gnt=2'b01.
//  2 req=2'b11 reads held 4 cycles, RD_LAT=1 -> gnt 01,10,01,10; rvalid follows one cycle later;
//    rdata matches preloaded RAM words.
//  3 req1 write addr 8'h10 data 16'hBEEF, next cycle req0 read 8'h10 -> rvalid[0] with rdata 16'hBEEF.
//  4 ARB_LOCK_EN, MAX_HOLD=4: req1+lock1 held, req0 held -> gnt[1] 4 cycles, then gnt[0];
//    no gnt[0] while LOCKED.
//  5 Read issued, rst asserted on the next cycle (RD_LAT=2) -> no rvalid ever appears; busy=0 after rst.
//  6 lock1 dropped in the same cycle req0 rises -> owner granted that cycle, gnt[0] on the next cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no grant last cycle
    ARB    = 2'd1,  // granted last cycle, ownership free
    LOCKED = 2'd2   // one requester owns the port
  } arb_state_t;

  localparam int DEF_NREQ = 2;
  localparam int DEF_AW   = 8;
  localparam int DEF_DW   = 16;

  // Index width; never below 1 so single-bit ids stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker: one-hot grant, search starts after i_last.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IDW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_last,
  output logic [NREQ-1:0] o_gnt
);

  logic w_found;

  // Walk requesters from last+1 wrapping around; first active one wins.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(i_last) + k) % NREQ;
      if (!w_found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NREQ requesters.
// Optional owner locking with forced release is enabled by defining ARB_LOCK_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_we,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int IDW = clog2(NREQ);

  arb_state_t                   r_state, w_state_nxt;
  logic [IDW-1:0]               r_last_gnt, w_last_nxt;
  logic [NREQ-1:0]              w_req_arb, w_pick;
  logic [IDW-1:0]               w_gnt_idx;
  logic                         w_any_gnt, w_push;
  logic [RD_LAT-1:0]            r_vld_pipe;
  logic [RD_LAT-1:0][IDW-1:0]   r_id_pipe;

`ifdef ARB_LOCK_EN
  localparam int HW = clog2(MAX_HOLD + 1);
  logic [IDW-1:0]  r_owner, w_owner_nxt;
  logic [HW-1:0]   r_hold_cnt, w_hold_nxt;
  logic [NREQ-1:0] w_owner_mask;

  // While locked only the owner is visible to the picker.
  always_comb begin
    w_owner_mask          = '0;
    w_owner_mask[r_owner] = 1'b1;
    w_req_arb             = (r_state == LOCKED) ? (req & w_owner_mask) : req;
  end
`else
  logic w_lock_unused;
  assign w_lock_unused = ^lock;
  assign w_req_arb     = req;
`endif

  mem_arb_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req  (w_req_arb),
    .i_last (r_last_gnt),
    .o_gnt  (w_pick)
  );

  // No access may issue while reset is held.
  assign gnt       = rst ? '0 : w_pick;
  assign w_any_gnt = |gnt;

  // One-hot grant to index, then steer the winner's fields onto the RAM port.
  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) w_gnt_idx = IDW'(i);
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (w_any_gnt) begin
      mem_addr  = req_addr[int'(w_gnt_idx)*AW +: AW];
      mem_we    = req_we[w_gnt_idx];
      mem_wdata = req_wdata[int'(w_gnt_idx)*DW +: DW];
    end
  end

  assign w_push = w_any_gnt & ~mem_we;

  // Read tag pipe: valid + requester id travel alongside the RAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
    end else begin
      r_vld_pipe[0] <= w_push;
      r_id_pipe[0]  <= w_gnt_idx;
      for (int s = 1; s < RD_LAT; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_id_pipe[s]  <= r_id_pipe[s-1];
      end
    end
  end

  // Decode the pipe tail into a one-hot return strobe.
  always_comb begin
    rvalid = '0;
    if (r_vld_pipe[RD_LAT-1]) rvalid[r_id_pipe[RD_LAT-1]] = 1'b1;
  end

  assign rdata = mem_rdata;
  assign busy  = (|r_vld_pipe) | (r_state == LOCKED);

  // State, round-robin pointer and lock bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_gnt <= IDW'(NREQ - 1);
`ifdef ARB_LOCK_EN
      r_owner    <= '0;
      r_hold_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_last_gnt <= w_last_nxt;
`ifdef ARB_LOCK_EN
      r_owner    <= w_owner_nxt;
      r_hold_cnt <= w_hold_nxt;
`endif
    end
  end

  // Next-state logic; a forced release parks the pointer on the owner.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = w_any_gnt ? w_gnt_idx : r_last_gnt;
`ifdef ARB_LOCK_EN
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold_cnt;
    if (r_state == LOCKED) begin
      // Idle owner cycles count toward the hold limit too.
      w_hold_nxt = r_hold_cnt + HW'(1);
      if (!lock[r_owner] || (int'(w_hold_nxt) >= MAX_HOLD)) begin
        w_state_nxt = ARB;
        w_last_nxt  = r_owner;
        w_hold_nxt  = '0;
      end
    end else if (w_any_gnt) begin
      if (lock[w_gnt_idx] && MAX_HOLD > 1) begin
        w_state_nxt = LOCKED;
        w_owner_nxt = w_gnt_idx;
        w_hold_nxt  = HW'(1);
      end else begin
        w_state_nxt = ARB;
      end
    end else begin
      w_state_nxt = IDLE;
    end
`else
    w_state_nxt = w_any_gnt ? ARB : IDLE;
`endif
  end

endmodule
